key_entry_seq: RTL and testbench
================================

# key_entry_seq

Parametrised keyboard entry sequencer: consumes scan codes from the PS/2 receiver, acts only on key releases (break prefix followed by the key code), and collects up to DEPTH digit codes in a shift buffer. Backspace removes the newest digit; Enter completes the entry. It replaces the fixed-sequence master FSM between the keyboard receiver and the downstream programming/control machine, and adds depth, backspace, overflow and an optional inactivity timeout.

## Interface
- CODE_W, 8, scan code width
- DEPTH, 4, maximum stored digits (≥1)
- BRK_CODE, 8'hF0, break prefix
- ENTER_CODE, 8'h5A, Enter key code
- BKSP_CODE, 8'h66, Backspace key code
- TIMEOUT_CYC, 50_000_000, inactivity limit in clk cycles (used only with KEY_TIMEOUT_EN)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- en  in  1  enables entry; low forces IDLE
- code  in  CODE_W  scan code, valid when code_ready=1
- code_ready  in  1  one-cycle strobe from receiver
- valid_key  in  1  external digit decode of code, sampled with code_ready
- entry_ack  in  1  downstream accepts completed entry
- buf_data  out  DEPTH*CODE_W  digits, newest in bits [CODE_W-1:0]
- count  out  $clog2(DEPTH+1)  number of stored digits
- entry_done  out  1  level, high in DONE
- overflow  out  1  sticky: digit rejected because buffer full
- busy  out  1  high in any state except IDLE
- timeout  out  1  one-cycle pulse on timeout (0 if macro absent)

## Operation
- States: IDLE, ARMED, BREAK, EVAL, DONE.
- IDLE: buffer, count, overflow cleared. en=1 -> ARMED.
- ARMED: code_ready with code==BRK_CODE -> BREAK; other codes (make codes) ignored.
- BREAK: next code_ready latches code/valid_key -> EVAL. A second BRK_CODE stays in BREAK.
- EVAL (one cycle), priority order:
  - code==ENTER_CODE and count>0 -> DONE; count==0 -> ARMED, ignored.
  - code==BKSP_CODE: count>0 -> shift buffer right by CODE_W, zero-fill top, count-1; count==0 ignored; -> ARMED.
  - valid_key=1: count<DEPTH -> shift left, insert code, count+1; count==DEPTH -> no store, overflow<=1; -> ARMED.
  - otherwise ignored -> ARMED.
- DONE: buffer frozen, code_ready ignored. entry_ack=1 -> clear buffer/count/overflow, -> ARMED.
- en=0 in any state -> IDLE next cycle, contents cleared; takes priority over all other inputs.
- Simultaneous entry_ack and code_ready in DONE: ack wins, code dropped.
- code_ready during EVAL is dropped (receiver spacing ≥2 cycles is guaranteed).

## Timing
- Reset (reset=0 at edge): state IDLE, buf_data=0, count=0, entry_done=0, overflow=0, busy=0, timeout=0. Reset mid-entry discards everything.
- Key-code strobe in BREAK at edge t -> EVAL during t+1 -> buf_data/count/overflow updated at t+2, entry_done high from t+2.
- entry_ack at edge t in DONE -> entry_done=0, count=0 at t+1.
- All outputs registered or decoded from registered state; no combinational input-to-output path.

## Configuration
- KEY_TIMEOUT_EN defined: counter cleared on every code_ready and on entering ARMED; counts in ARMED and BREAK; reaching TIMEOUT_CYC-1 clears buffer, count, overflow, pulses timeout for one cycle, -> ARMED. Counter inactive in IDLE, EVAL, DONE.
- Undefined: no counter, timeout tied 0, TIMEOUT_CYC unused.

## Structure
- Package key_pkg: state enum, default BRK_CODE/ENTER_CODE/BKSP_CODE constants.
- Sub-module key_entry_buf: DEPTH×CODE_W shift buffer with push, pop, clear and count, full/empty flags; sequencer instantiates one.

## Test plan
- Reset, en=1, release "1" (F0,16) then "2" (F0,1E) -> count=2, buf_data[15:0]=16'h161E at t+2 after last strobe.
- Five digit releases with DEPTH=4 -> count=4, fifth code absent, overflow=1; entry_ack clears overflow.
- Digits 16,1E, then F0,66 -> count=1, buf_data[7:0]=8'h16; Backspace on empty -> no change.
- Enter with count=0 -> stays ARMED; digits 16,1E then F0,5A -> entry_done=1; code_ready in DONE ignored; entry_ack -> entry_done=0, count=0.
- en dropped mid-BREAK, and reset=0 during DONE -> IDLE, all outputs 0 next cycle.
- KEY_TIMEOUT_EN, TIMEOUT_CYC=100: one digit then 100 idle cycles -> timeout pulse, count=0; strobe at cycle 99 restarts count, no timeout.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default key codes for the keyboard entry sequencer.
package key_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_BREAK = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } key_state_e;

  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;

endpackage

// File: rtl/key_entry_buf.sv
// DEPTH x CODE_W digit shift buffer: push inserts at the low end, pop drops the
// newest digit and zero-fills the top.
module key_entry_buf #(
  parameter  int unsigned CODE_W = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned DATA_W = DEPTH * CODE_W,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [CODE_W-1:0] din_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (push_i && !full_o) begin
      data_q  <= (data_q << CODE_W) | DATA_W'(din_i);
      count_q <= count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      data_q  <= data_q >> CODE_W;
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/key_entry_seq.sv
// Keyboard entry sequencer: acts on key releases (break prefix + code), collects
// digits, handles Backspace/Enter. Optional inactivity timeout: KEY_TIMEOUT_EN.
//
// state | meaning
// IDLE  | disabled, buffer/count/overflow held clear
// ARMED | waiting for a break prefix; make codes ignored
// BREAK | break seen, next code is the released key
// EVAL  | one cycle to act on the latched key
// DONE  | entry complete, buffer frozen until entry_ack
module key_entry_seq
  import key_pkg::*;
#(
  parameter int unsigned        CODE_W      = 8,
  parameter int unsigned        DEPTH       = 4,
  parameter logic [CODE_W-1:0]  BRK_CODE    = KEY_BRK,
  parameter logic [CODE_W-1:0]  ENTER_CODE  = KEY_ENTER,
  parameter logic [CODE_W-1:0]  BKSP_CODE   = KEY_BKSP,
  parameter int unsigned        TIMEOUT_CYC = 50_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [CODE_W-1:0]             code,
  input  logic                          code_ready,
  input  logic                          valid_key,
  input  logic                          entry_ack,
  output logic [DEPTH*CODE_W-1:0]       buf_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          entry_done,
  output logic                          overflow,
  output logic                          busy,
  output logic                          timeout
);

  // A degenerate configuration holds the sequencer idle instead of misbehaving.
  localparam bit CFG_OK = (DEPTH >= 1) && (TIMEOUT_CYC >= 2);

  key_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              buf_clr, buf_push, buf_pop;
  logic              buf_full, buf_empty;
  logic              en_ok;
  logic              tmo_fire;

  assign en_ok = en & CFG_OK;

  key_entry_buf #(.CODE_W(CODE_W), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (buf_clr),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .din_i   (code_q),
    .data_o  (buf_data),
    .count_o (count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

`ifdef KEY_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_q;
  logic             timeout_q;
  logic             tmo_counting;

  assign tmo_counting = (state_q == S_ARMED) || (state_q == S_BREAK);
  // A strobe on the limit cycle counts as activity and wins over the timeout.
  assign tmo_fire = en_ok && tmo_counting && !code_ready &&
                    (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_fire;
      if (code_ready || tmo_fire || !tmo_counting ||
          (state_d == S_ARMED && state_q != S_ARMED))
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    buf_clr  = 1'b0;
    buf_push = 1'b0;
    buf_pop  = 1'b0;

    if (!en_ok) begin
      state_d = S_IDLE;
      buf_clr = 1'b1;
      ovf_d   = 1'b0;
    end else if (tmo_fire) begin
      state_d = S_ARMED;
      buf_clr = 1'b1;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          buf_clr = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_ARMED;
        end
        S_ARMED: begin
          if (code_ready && code == BRK_CODE) state_d = S_BREAK;
        end
        S_BREAK: begin
          if (code_ready && code != BRK_CODE) begin
            code_d  = code;
            valid_d = valid_key;
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          state_d = S_ARMED;
          if (code_q == ENTER_CODE) begin
            if (!buf_empty) state_d = S_DONE;
          end else if (code_q == BKSP_CODE) begin
            buf_pop = 1'b1;
          end else if (valid_q) begin
            if (buf_full) ovf_d = 1'b1;
            else          buf_push = 1'b1;
          end
        end
        S_DONE: begin
          if (entry_ack) begin
            buf_clr = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_ARMED;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign entry_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_key_entry_seq.sv
// Directed bench for key_entry_seq (DEPTH=4, 8-bit codes); the timeout scenario
// runs when KEY_TIMEOUT_EN is defined.
module tb_key_entry_seq;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      en = 1'b0;
  logic [CODE_W-1:0]         code = '0;
  logic                      code_ready = 1'b0;
  logic                      valid_key = 1'b0;
  logic                      entry_ack = 1'b0;
  logic [DEPTH*CODE_W-1:0]   buf_data;
  logic [2:0]                count;
  logic                      entry_done;
  logic                      overflow;
  logic                      busy;
  logic                      timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  key_entry_seq #(.CODE_W(CODE_W), .DEPTH(DEPTH), .TIMEOUT_CYC(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .code       (code),
    .code_ready (code_ready),
    .valid_key  (valid_key),
    .entry_ack  (entry_ack),
    .buf_data   (buf_data),
    .count      (count),
    .entry_done (entry_done),
    .overflow   (overflow),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One receiver strobe followed by one quiet cycle; for a key code sent in
  // BREAK the result of EVAL is visible on return.
  task automatic send(input logic [7:0] c, input logic vk);
    code       = c;
    valid_key  = vk;
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    valid_key  = 1'b0;
    tick();
  endtask

  task automatic key_release(input logic [7:0] c, input logic vk);
    send(8'hF0, 1'b0);
    send(c, vk);
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({buf_data, count, entry_done, overflow, busy, timeout} !== '0) begin
      tests_failed++;
      $display("FAIL %s: buf=%h count=%0d done=%b ovf=%b busy=%b tmo=%b, required all 0",
               name, buf_data, count, entry_done, overflow, busy, timeout);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    tick();
    tick();
    check_all_zero("reset_state");
    reset = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL arm_after_reset: busy=%b required 1", busy);
    end
  endtask

  task automatic test_digits();
    restart();
    send(8'h16, 1'b1);
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++;
      $display("FAIL make_code_ignored: count=%0d required 0", count);
    end
    key_release(8'h16, 1'b1);
    send(8'hF0, 1'b0);
    code = 8'h1E; valid_key = 1'b1; code_ready = 1'b1;
    tick();
    code_ready = 1'b0; valid_key = 1'b0;
    tests_run++;
    if (count !== 3'd1) begin
      tests_failed++;
      $display("FAIL eval_latency: count=%0d required 1 during EVAL", count);
    end
    tick();
    tests_run++;
    if (count !== 3'd2 || buf_data[15:0] !== 16'h161E) begin
      tests_failed++;
      $display("FAIL two_digits: count=%0d buf=%h required 2 / 161E", count, buf_data[15:0]);
    end
    key_release(8'h1C, 1'b0);
    tests_run++;
    if (count !== 3'd2 || buf_data !== 32'h0000161E) begin
      tests_failed++;
      $display("FAIL non_digit_ignored: count=%0d buf=%h required 2 / 0000161E", count, buf_data);
    end
  endtask

  task automatic test_overflow();
    restart();
    key_release(8'h16, 1'b1);
    key_release(8'h1E, 1'b1);
    key_release(8'h26, 1'b1);
    key_release(8'h25, 1'b1);
    tests_run++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_no_ovf: count=%0d ovf=%b required 4 / 0", count, overflow);
    end
    key_release(8'h2E, 1'b1);
    tests_run++;
    if (count !== 3'd4 || buf_data !== 32'h161E2625 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow: count=%0d buf=%h ovf=%b required 4 / 161E2625 / 1",
               count, buf_data, overflow);
    end
    key_release(8'h5A, 1'b0);
    entry_ack = 1'b1;
    tick();
    entry_ack = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || count !== 3'd0 || entry_done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_clears_ovf: ovf=%b count=%0d done=%b busy=%b required 0/0/0/1",
               overflow, count, entry_done, busy);
    end
  endtask

  task automatic test_backspace();
    restart();
    key_release(8'h16, 1'b1);
    key_release(8'h1E, 1'b1);
    key_release(8'h66, 1'b0);
    tests_run++;
    if (count !== 3'd1 || buf_data !== 32'h00000016) begin
      tests_failed++;
      $display("FAIL backspace: count=%0d buf=%h required 1 / 00000016", count, buf_data);
    end
    key_release(8'h66, 1'b0);
    key_release(8'h66, 1'b0);
    tests_run++;
    if (count !== 3'd0 || buf_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL backspace_empty: count=%0d buf=%h required 0 / 0", count, buf_data);
    end
  endtask

  task automatic test_enter();
    restart();
    key_release(8'h5A, 1'b0);
    tests_run++;
    if (entry_done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL enter_empty: done=%b busy=%b required 0 / 1", entry_done, busy);
    end
    key_release(8'h16, 1'b1);
    key_release(8'h1E, 1'b1);
    key_release(8'h5A, 1'b0);
    tests_run++;
    if (entry_done !== 1'b1 || count !== 3'd2 || buf_data !== 32'h0000161E) begin
      tests_failed++;
      $display("FAIL enter_done: done=%b count=%0d buf=%h required 1 / 2 / 0000161E",
               entry_done, count, buf_data);
    end
    key_release(8'h26, 1'b1);
    tests_run++;
    if (entry_done !== 1'b1 || count !== 3'd2 || buf_data !== 32'h0000161E) begin
      tests_failed++;
      $display("FAIL done_frozen: done=%b count=%0d buf=%h required 1 / 2 / 0000161E",
               entry_done, count, buf_data);
    end
    entry_ack = 1'b1; code = 8'hF0; valid_key = 1'b0; code_ready = 1'b1;
    tick();
    entry_ack = 1'b0; code_ready = 1'b0;
    tests_run++;
    if (entry_done !== 1'b0 || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL ack: done=%b count=%0d required 0 / 0", entry_done, count);
    end
    tick();
    send(8'h16, 1'b1);
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++;
      $display("FAIL ack_drops_code: count=%0d required 0", count);
    end
  endtask

  task automatic test_abort();
    restart();
    key_release(8'h16, 1'b1);
    send(8'hF0, 1'b0);
    en = 1'b0;
    tick();
    check_all_zero("en_drop_break");
    en = 1'b1;
    tick();
    key_release(8'h16, 1'b1);
    key_release(8'h5A, 1'b0);
    reset = 1'b0;
    tick();
    check_all_zero("reset_in_done");
    reset = 1'b1;
    tick();
  endtask

`ifdef KEY_TIMEOUT_EN
  task automatic test_timeout();
    restart();
    key_release(8'h16, 1'b1);
    repeat (99) tick();
    tests_run++;
    if (timeout !== 1'b0 || count !== 3'd1) begin
      tests_failed++;
      $display("FAIL tmo_early: tmo=%b count=%0d required 0 / 1", timeout, count);
    end
    tick();
    tests_run++;
    if (timeout !== 1'b1 || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL tmo_pulse: tmo=%b count=%0d required 1 / 0", timeout, count);
    end
    tick();
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_one_cycle: tmo=%b required 0", timeout);
    end
    key_release(8'h16, 1'b1);
    repeat (99) tick();
    code = 8'h11; code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    repeat (98) tick();
    tests_run++;
    if (timeout !== 1'b0 || count !== 3'd1) begin
      tests_failed++;
      $display("FAIL tmo_restart: tmo=%b count=%0d required 0 / 1", timeout, count);
    end
  endtask
`else
  task automatic test_timeout();
    restart();
    key_release(8'h16, 1'b1);
    repeat (120) tick();
    tests_run++;
    if (timeout !== 1'b0 || count !== 3'd1) begin
      tests_failed++;
      $display("FAIL no_timeout: tmo=%b count=%0d required 0 / 1", timeout, count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_digits();
    test_overflow();
    test_backspace();
    test_enter();
    test_abort();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
